vnu_bitserial_link: RTL and testbench
=====================================

Name: vnu_bitserial_link

Overview:
- VNU-side endpoint of the half-duplex bit-serial message link between variable-node and check-node units.
- Per edge, latches DEGREE v2c messages and serializes them MSB-first onto the shared serial wires. It then releases the wires, receives the c2v replies serially, and presents them in parallel.
- Also generates the CNU-side port controls: `cnu_load` and `cnu_parallel_en`, shared by all CNU edge interfaces.

Parameters:
- `MSG_WIDTH`, 4, bits per message, in either direction. Legal range is 2..8.
- `CN_DEGREE`, 6, number of edges / serial wires served.

Ports:
- `sys_clk`  in  1  link clock; all state changes on its rising edge.
- `rstn`  in  1  asynchronous active-low reset.
- `start`  in  1  request one exchange; sampled only in IDLE.
- `v2c_parallelIn`  in  `CN_DEGREE*MSG_WIDTH`  v2c messages; edge i occupies bits `[i*MSG_WIDTH +: MSG_WIDTH]`.
- `serialInOut`  inout  `CN_DEGREE`  one serial wire per edge. Driven by this block only in TX; otherwise high-Z.
- `c2v_parallelOut`  out  `CN_DEGREE*MSG_WIDTH`  received c2v messages, same packing as `v2c_parallelIn`.
- `c2v_valid`  out  1  one-cycle pulse when `c2v_parallelOut` is updated.
- `busy`  out  1  high in every state except IDLE.
- `cnu_parallel_en`  out  1  high during TX; CNU shifts serial bits into its parallel register.
- `cnu_load`  out  1  high during TURN; CNU loads its c2v parallel words into its shift registers.

Behaviour:
- Reset (`rstn`=0, asynchronous, at any time, including mid-exchange):
  - state goes to IDLE; bit counter is 0.
  - `serialInOut` is all high-Z.
  - `c2v_parallelOut`=0; `c2v_valid`, `busy`, `cnu_parallel_en` and `cnu_load` are all 0.
  - The shift registers are cleared.
- FSM states are IDLE, TX, TURN, RX, DONE. Outputs are decoded from the registered state.
- IDLE:
  - On a rising edge with `start`=1, capture `v2c_parallelIn` into the per-edge TX shift registers, clear the counter, and go to TX.
  - `start`=0 stays in IDLE.
- TX (exactly `MSG_WIDTH` cycles):
  - Wire i drives the current MSB of TX register i; the register shifts left by 1 each edge. Bit order is `MSG_WIDTH-1` down to 0.
  - The counter increments each edge. When counter=`MSG_WIDTH-1`, reset the counter and go to TURN.
  - `cnu_parallel_en`=1 throughout TX.
- TURN (exactly 1 cycle):
  - All wires are high-Z, which gives a bus turnaround with no overlap of drivers.
  - `cnu_load`=1.
  - Next state is RX.
- RX (exactly `MSG_WIDTH` cycles):
  - Each edge, RX register i = {RX register i[`MSG_WIDTH-2`:0], `serialInOut[i]`}, so the first received bit ends up as the MSB.
  - When counter=`MSG_WIDTH-1`, go to DONE.
  - A high-Z/X sample is captured as-is; no masking.
- DONE (1 cycle):
  - `c2v_parallelOut` is updated from the RX registers at the edge entering DONE; `c2v_valid`=1 during DONE.
  - Next state is IDLE.
  - `c2v_parallelOut` holds its value until the next DONE or reset.
- Latency: `start` sampled at edge 0 → TX cycles 1..W, TURN at W+1, RX W+2..2W+1, DONE 2W+2. For W=4: `c2v_valid` is high in cycle 10, and a back-to-back `start` in IDLE is accepted at edge 11.
- `start` outside IDLE is ignored. It is not queued and does not disturb the ongoing exchange.
- `v2c_parallelIn` changes after capture have no effect until the next exchange.
- `busy`=1 from TX through DONE inclusive.
- Widths: the counter is `clog2(MSG_WIDTH)` bits with no wrap beyond `MSG_WIDTH-1`. No arithmetic is performed on the message contents.

Test Plan:
1. Reset then idle, W=4, D=6: hold `rstn`=0 then release → wires Z; `c2v_parallelOut`=0; `busy`=0; no `cnu_*` activity for 20 cycles.
2. Single exchange:
   - Stimulus: `v2c` edge0=4'hA, edge5=4'h3; loopback model returns c2v edge0=4'h5, edge5=4'hC.
   - Required: wire0 carries 1,0,1,0 in cycles 1-4; wire5 carries 0,0,1,1.
   - Required: `cnu_parallel_en`=1 in cycles 1-4 and `cnu_load`=1 in cycle 5.
   - Required: `c2v_valid` pulses in cycle 10 with edge0=4'h5, edge5=4'hC.
3. Turnaround check: the bench monitors all wires in the TURN cycle → all high-Z; no cycle with both ends driving.
4. `start` held high continuously → exchanges start at edges 0, 11, 22; `start` pulses in cycles 3 and 7 have no effect.
5. Reset mid-exchange: assert `rstn`=0 in RX cycle 7 → immediate IDLE, wires Z, `c2v_parallelOut`=0, no `c2v_valid`. The next `start` completes normally.
6. Input change after capture: change `v2c_parallelIn` in cycle 2 → the serial stream still carries the values captured at edge 0.

Source files
------------

// File: rtl/vnu_bitserial_link_if.sv
// Parallel-side and control signals of the VNU bit-serial link.
//   master : requester (drives start and the v2c words, observes results)
//   slave  : vnu_bitserial_link endpoint
// Signals:
//   start            request one exchange
//   v2c_parallelIn   CN_DEGREE packed v2c words, edge i at [i*MSG_WIDTH +: MSG_WIDTH]
//   c2v_parallelOut  CN_DEGREE packed c2v words, same packing
//   c2v_valid        one-cycle pulse when c2v_parallelOut is updated
//   busy             exchange in progress
//   cnu_parallel_en  CNU shifts serial bits into its parallel register
//   cnu_load         CNU loads its c2v words into its shift registers
interface vnu_bitserial_link_if #(
    parameter int MSG_WIDTH = 4,
    parameter int CN_DEGREE = 6
);
    logic                           start;
    logic [CN_DEGREE*MSG_WIDTH-1:0] v2c_parallelIn;
    logic [CN_DEGREE*MSG_WIDTH-1:0] c2v_parallelOut;
    logic                           c2v_valid;
    logic                           busy;
    logic                           cnu_parallel_en;
    logic                           cnu_load;

    modport master (
        output start, v2c_parallelIn,
        input  c2v_parallelOut, c2v_valid, busy, cnu_parallel_en, cnu_load
    );

    modport slave (
        input  start, v2c_parallelIn,
        output c2v_parallelOut, c2v_valid, busy, cnu_parallel_en, cnu_load
    );
endinterface

// File: rtl/vnu_bitserial_link.sv
// VNU-side endpoint of the half-duplex bit-serial link to the check-node units.
// Latches CN_DEGREE v2c words, shifts them out MSB-first on one wire per edge,
// releases the wires for one turnaround cycle, shifts the c2v replies back in
// and presents them in parallel with a one-cycle valid pulse.
// Ports:
//   sys_clk      link clock, rising edge
//   rstn         asynchronous active-low reset
//   serialInOut  one bidirectional serial wire per edge; driven only in TX
//   link         vnu_bitserial_link_if slave modport (start, v2c/c2v words,
//                c2v_valid, busy, cnu_parallel_en, cnu_load)
module vnu_bitserial_link #(
    parameter int MSG_WIDTH = 4,
    parameter int CN_DEGREE = 6
) (
    input  logic                  sys_clk,
    input  logic                  rstn,
    inout  wire  [CN_DEGREE-1:0]  serialInOut,
    vnu_bitserial_link_if.slave   link
);
    localparam int CW = (MSG_WIDTH > 1) ? $clog2(MSG_WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MSG_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, TX, TURN, RX, DONE} state_t;

    state_t                         state;
    logic [CW-1:0]                  cnt;
    logic [MSG_WIDTH-1:0]           tx_sr   [CN_DEGREE];
    logic [MSG_WIDTH-1:0]           rx_sr   [CN_DEGREE];
    logic [MSG_WIDTH-1:0]           rx_next [CN_DEGREE];
    logic [CN_DEGREE*MSG_WIDTH-1:0] c2v_q;
    logic                           valid_q;
    logic                           busy_q;
    logic                           pen_q;
    logic                           load_q;

    // Wires are driven only while pen_q is high, i.e. exactly the TX cycles.
    for (genvar g = 0; g < CN_DEGREE; g++) begin : g_wire
        assign serialInOut[g] = pen_q ? tx_sr[g][MSG_WIDTH-1] : 1'bz;
    end

    always_comb begin
        for (int unsigned i = 0; i < CN_DEGREE; i++) begin
            rx_next[i] = {rx_sr[i][MSG_WIDTH-2:0], serialInOut[i]};
        end
    end

    // Output flags are registered together with the state transition so they
    // always reflect the state being entered.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            c2v_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            pen_q   <= 1'b0;
            load_q  <= 1'b0;
            for (int unsigned i = 0; i < CN_DEGREE; i++) begin
                tx_sr[i] <= '0;
                rx_sr[i] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (link.start) begin
                        for (int unsigned i = 0; i < CN_DEGREE; i++) begin
                            tx_sr[i] <= link.v2c_parallelIn[i*MSG_WIDTH +: MSG_WIDTH];
                        end
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        pen_q  <= 1'b1;
                        state  <= TX;
                    end
                end
                TX: begin
                    for (int unsigned i = 0; i < CN_DEGREE; i++) begin
                        tx_sr[i] <= {tx_sr[i][MSG_WIDTH-2:0], 1'b0};
                    end
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        pen_q  <= 1'b0;
                        load_q <= 1'b1;
                        state  <= TURN;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TURN: begin
                    load_q <= 1'b0;
                    state  <= RX;
                end
                RX: begin
                    for (int unsigned i = 0; i < CN_DEGREE; i++) begin
                        rx_sr[i] <= rx_next[i];
                    end
                    if (cnt == CNT_LAST) begin
                        // Last bit arrives on this same edge, so the output
                        // word is taken from the shifted value, not rx_sr.
                        for (int unsigned i = 0; i < CN_DEGREE; i++) begin
                            c2v_q[i*MSG_WIDTH +: MSG_WIDTH] <= rx_next[i];
                        end
                        cnt     <= '0;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    cnt    <= '0;
                    busy_q <= 1'b0;
                    pen_q  <= 1'b0;
                    load_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign link.c2v_parallelOut = c2v_q;
    assign link.c2v_valid       = valid_q;
    assign link.busy            = busy_q;
    assign link.cnu_parallel_en = pen_q;
    assign link.cnu_load        = load_q;
endmodule

// File: tb/tb_vnu_bitserial_link.sv
// Bench for vnu_bitserial_link: a CNU loopback model answers each exchange
// on the serial wires; expected stream, control timing and received words are
// derived from the exchange schedule (TX 1..W, TURN W+1, RX W+2..2W+1,
// DONE 2W+2). Undriven wires are weakly pulled up, so "released" reads as 1.
module tb_vnu_bitserial_link;
    localparam int W  = 4;
    localparam int D  = 6;
    localparam int DW = D * W;

    logic          sys_clk = 1'b0;
    logic          rstn    = 1'b0;
    wire  [D-1:0]  serial;
    logic          cnu_en   = 1'b0;
    logic [D-1:0]  cnu_bits = '0;
    logic [DW-1:0] prev_out = '0;
    int            n_cmp = 0;
    int            n_err = 0;

    vnu_bitserial_link_if #(.MSG_WIDTH(W), .CN_DEGREE(D)) link ();

    vnu_bitserial_link #(.MSG_WIDTH(W), .CN_DEGREE(D)) dut (
        .sys_clk     (sys_clk),
        .rstn        (rstn),
        .serialInOut (serial),
        .link        (link.slave)
    );

    assign serial = cnu_en ? cnu_bits : 'z;
    for (genvar g = 0; g < D; g++) begin : g_pu
        pullup (serial[g]);
    end

    always #5 sys_clk = ~sys_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [DW-1:0] rand_words();
        logic [DW-1:0] v;
        for (int i = 0; i < D; i++) v[i*W +: W] = W'($urandom_range(0, (1 << W) - 1));
        return v;
    endfunction

    // One exchange, starting from IDLE. hold keeps start high; pulses fires
    // start in cycles 3 and 7; chg scrambles v2c in cycle 2; abort_at>0
    // asserts reset in that cycle and abandons the exchange.
    task automatic run_exchange(input logic [DW-1:0] v2c, input logic [DW-1:0] c2v,
                                input bit hold, input bit pulses, input bit chg,
                                input int abort_at);
        logic [D-1:0]  exp_w;
        logic [3:0]    exp_ctl;
        logic [DW-1:0] exp_out;
        @(posedge sys_clk); #1;
        n_cmp++;
        if (link.busy !== 1'b0) begin
            n_err++; $display("FAIL idle_busy: got %b expected 0", link.busy);
        end
        link.start = 1'b1;
        link.v2c_parallelIn = v2c;
        for (int c = 1; c <= 2*W + 2; c++) begin
            @(posedge sys_clk); #1;
            link.start = hold ? 1'b1 : (pulses && (c == 3 || c == 7));
            if (chg && c == 2) link.v2c_parallelIn = ~v2c;
            if (c >= W + 2 && c <= 2*W + 1) begin
                cnu_en = 1'b1;
                for (int i = 0; i < D; i++) cnu_bits[i] = c2v[i*W + (W - 1 - (c - W - 2))];
            end else begin
                cnu_en = 1'b0;
            end
            if (c == abort_at) begin
                rstn = 1'b0;
                cnu_en = 1'b0;
                link.start = 1'b0;
                #1;
                n_cmp++;
                if (serial !== '1 || link.c2v_parallelOut !== '0 ||
                    {link.busy, link.cnu_parallel_en, link.cnu_load, link.c2v_valid} !== 4'b0) begin
                    n_err++;
                    $display("FAIL abort_reset: wires=%b out=%h ctl=%b expected wires=%b out=0 ctl=0000",
                             serial, link.c2v_parallelOut,
                             {link.busy, link.cnu_parallel_en, link.cnu_load, link.c2v_valid}, {D{1'b1}});
                end
                repeat (2) @(posedge sys_clk);
                @(negedge sys_clk);
                rstn = 1'b1;
                prev_out = '0;
                return;
            end
            @(negedge sys_clk);
            exp_ctl = {1'b1, (c <= W), (c == W + 1), (c == 2*W + 2)};
            n_cmp++;
            if ({link.busy, link.cnu_parallel_en, link.cnu_load, link.c2v_valid} !== exp_ctl) begin
                n_err++;
                $display("FAIL ctrl cycle %0d: got %b expected %b (busy,pen,load,valid)", c,
                         {link.busy, link.cnu_parallel_en, link.cnu_load, link.c2v_valid}, exp_ctl);
            end
            if (!(c >= W + 2 && c <= 2*W + 1)) begin
                for (int i = 0; i < D; i++) exp_w[i] = (c <= W) ? v2c[i*W + (W - c)] : 1'b1;
                n_cmp++;
                if (serial !== exp_w) begin
                    n_err++;
                    $display("FAIL wires cycle %0d: got %b expected %b", c, serial, exp_w);
                end
            end
            exp_out = (c == 2*W + 2) ? c2v : prev_out;
            n_cmp++;
            if (link.c2v_parallelOut !== exp_out) begin
                n_err++;
                $display("FAIL c2v_out cycle %0d: got %h expected %h", c, link.c2v_parallelOut, exp_out);
            end
        end
        prev_out = c2v;
        if (!hold) link.start = 1'b0;
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge sys_clk);
            n_cmp++;
            if ({link.busy, link.cnu_parallel_en, link.cnu_load, link.c2v_valid} !== 4'b0 ||
                serial !== '1 || link.c2v_parallelOut !== prev_out) begin
                n_err++;
                $display("FAIL %s idle %0d: ctl=%b wires=%b out=%h expected ctl=0000 wires=%b out=%h",
                         tag, k, {link.busy, link.cnu_parallel_en, link.cnu_load, link.c2v_valid},
                         serial, link.c2v_parallelOut, {D{1'b1}}, prev_out);
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        link.start = 1'b0;
        link.v2c_parallelIn = rand_words();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        n_cmp++;
        if (serial !== '1 || link.c2v_parallelOut !== '0 ||
            {link.busy, link.cnu_parallel_en, link.cnu_load, link.c2v_valid} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_state: wires=%b out=%h ctl=%b expected wires=%b out=0 ctl=0000",
                     serial, link.c2v_parallelOut,
                     {link.busy, link.cnu_parallel_en, link.cnu_load, link.c2v_valid}, {D{1'b1}});
        end
        rstn = 1'b1;
        prev_out = '0;
        idle_cycles(20, "reset");
    endtask

    task automatic test_single();
        logic [DW-1:0] v, r;
        v = rand_words(); r = rand_words();
        v[0 +: W] = 4'hA; v[5*W +: W] = 4'h3;
        r[0 +: W] = 4'h5; r[5*W +: W] = 4'hC;
        run_exchange(v, r, 1'b0, 1'b0, 1'b0, 0);
        n_cmp++;
        if (link.c2v_parallelOut[0 +: W] !== 4'h5 || link.c2v_parallelOut[5*W +: W] !== 4'hC) begin
            n_err++;
            $display("FAIL single_words: got e0=%h e5=%h expected e0=5 e5=c",
                     link.c2v_parallelOut[0 +: W], link.c2v_parallelOut[5*W +: W]);
        end
    endtask

    task automatic test_turnaround();
        run_exchange('1, rand_words(), 1'b0, 1'b0, 1'b0, 0);
        run_exchange('0, '1, 1'b0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 4; k++) run_exchange(rand_words(), rand_words(), 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) run_exchange(rand_words(), rand_words(), 1'b1, 1'b0, 1'b0, 0);
        link.start = 1'b0;
        run_exchange(rand_words(), rand_words(), 1'b0, 1'b1, 1'b0, 0);
        idle_cycles(12, "no_queue");
    endtask

    task automatic test_reset_mid();
        run_exchange(rand_words(), rand_words(), 1'b0, 1'b0, 1'b0, 7);
        idle_cycles(12, "post_abort");
        run_exchange(rand_words(), rand_words(), 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_input_change();
        run_exchange(rand_words(), rand_words(), 1'b0, 1'b0, 1'b1, 0);
        run_exchange(rand_words(), rand_words(), 1'b0, 1'b0, 1'b1, 0);
    endtask

    initial begin
        link.start = 1'b0;
        link.v2c_parallelIn = '0;
        test_reset();
        test_single();
        test_turnaround();
        test_back_to_back();
        test_reset_mid();
        test_input_change();
        repeat (2) @(posedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
